// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffered common-data-bus arbiter.
// Collects results from FU_NUM functional units through small per-FU FIFOs.
// Broadcasts up to CDB_NUM of them per cycle, in round-robin order, on
// registered output channels.
//
// Ports:
//   clock, reset_n           - clock, async active-low reset
//   flush                    - synchronous squash of buffered and registered results
//   fu_valid/fu_value/fu_tag - per-FU completion handshake and payload
//   fu_ready                 - per-FU space available (from registered occupancy)
//   cdb_valid/tag/value/src  - per-channel registered broadcast

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package cdb_arbiter_pkg;
   localparam int unsigned XLEN_W = `XLEN;
   localparam int unsigned TAG_W  = `ROB_TAG_LEN;

   // One buffered completion: destination ROB tag plus result data
   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [XLEN_W-1:0] value;
   } cdb_entry_t;
endpackage

module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned  FU_NUM    = 4,
   parameter int unsigned  CDB_NUM   = 2,
   parameter int unsigned  BUF_DEPTH = 2,
   localparam int unsigned SRC_W     = $clog2(FU_NUM)
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              flush,
   input  logic [FU_NUM-1:0]                 fu_valid,
   input  logic [FU_NUM-1:0][XLEN_W-1:0]     fu_value,
   input  logic [FU_NUM-1:0][TAG_W-1:0]      fu_tag,
   output logic [FU_NUM-1:0]                 fu_ready,
   output logic [CDB_NUM-1:0]                cdb_valid,
   output logic [CDB_NUM-1:0][TAG_W-1:0]     cdb_tag,
   output logic [CDB_NUM-1:0][XLEN_W-1:0]    cdb_value,
   output logic [CDB_NUM-1:0][SRC_W-1:0]     cdb_src
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CH_W  = (CDB_NUM > 1) ? $clog2(CDB_NUM) : 1;

   // FIFO storage and bookkeeping, one FIFO per FU
   cdb_entry_t        r_mem    [FU_NUM][BUF_DEPTH];
   logic [CNT_W-1:0]  r_count  [FU_NUM];
   logic [PTR_W-1:0]  r_rd_ptr [FU_NUM];
   logic [PTR_W-1:0]  r_wr_ptr [FU_NUM];
   logic [SRC_W-1:0]  r_rr_ptr;

   logic [FU_NUM-1:0] w_push;
   logic [FU_NUM-1:0] w_grant;
   cdb_entry_t        w_head     [FU_NUM];
   logic [CDB_NUM-1:0] w_ch_valid;
   cdb_entry_t        w_ch_entry [CDB_NUM];
   logic [SRC_W-1:0]  w_ch_src   [CDB_NUM];
   logic [SRC_W-1:0]  w_rr_next;

   // Circular pointer increment that also works for non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // Ready depends only on registered occupancy, so a full FIFO stalls even
   // in a cycle where it pops.
   always_comb begin
      for (int i = 0; i < FU_NUM; i++) begin
         fu_ready[i] = reset_n && (r_count[i] < CNT_W'(BUF_DEPTH));
         w_push[i]   = fu_valid[i] && fu_ready[i] && !flush;
         w_head[i]   = r_mem[i][r_rd_ptr[i]];
      end
   end

   // Round-robin scan from r_rr_ptr; grants are packed from channel 0 upward
   always_comb begin
      int unsigned v_idx;
      int unsigned v_n;
      int unsigned v_last;
      v_idx      = 0;
      v_n        = 0;
      v_last     = 0;
      w_grant    = '0;
      w_ch_valid = '0;
      for (int c = 0; c < CDB_NUM; c++) begin
         w_ch_entry[c] = '0;
         w_ch_src[c]   = '0;
      end
      for (int unsigned k = 0; k < FU_NUM; k++) begin
         v_idx = 32'(r_rr_ptr) + k;
         if (v_idx >= FU_NUM) begin
            v_idx = v_idx - FU_NUM;
         end
         if ((r_count[SRC_W'(v_idx)] != '0) && (v_n < CDB_NUM)) begin
            w_grant[SRC_W'(v_idx)]    = 1'b1;
            w_ch_valid[CH_W'(v_n)]    = 1'b1;
            w_ch_entry[CH_W'(v_n)]    = w_head[SRC_W'(v_idx)];
            w_ch_src[CH_W'(v_n)]      = SRC_W'(v_idx);
            v_last                    = v_idx;
            v_n                       = v_n + 1;
         end
      end
      // Pointer moves just past the last FU granted in scan order
      w_rr_next = (v_last == FU_NUM - 1) ? '0 : SRC_W'(v_last + 1);
   end

   // FIFO occupancy and pointers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FU_NUM; i++) begin
            r_count[i]  <= '0;
            r_rd_ptr[i] <= '0;
            r_wr_ptr[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < FU_NUM; i++) begin
            r_count[i]  <= '0;
            r_rd_ptr[i] <= '0;
            r_wr_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FU_NUM; i++) begin
            if (w_push[i]) begin
               r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
            end
            if (w_grant[i]) begin
               r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
            end
            if (w_push[i] && !w_grant[i]) begin
               r_count[i] <= r_count[i] + CNT_W'(1);
            end else if (!w_push[i] && w_grant[i]) begin
               r_count[i] <= r_count[i] - CNT_W'(1);
            end
         end
      end
   end

   // FIFO data storage; no reset needed, occupancy gates visibility
   always_ff @(posedge clock) begin
      for (int i = 0; i < FU_NUM; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wr_ptr[i]] <= cdb_entry_t'{tag: fu_tag[i], value: fu_value[i]};
         end
      end
   end

   // Registered broadcast channels and round-robin pointer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr  <= '0;
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else if (flush) begin
         r_rr_ptr  <= '0;
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else begin
         if (w_grant != '0) begin
            r_rr_ptr <= w_rr_next;
         end
         cdb_valid <= w_ch_valid;
         for (int c = 0; c < CDB_NUM; c++) begin
            cdb_tag[c]   <= w_ch_entry[c].tag;
            cdb_value[c] <= w_ch_entry[c].value;
            cdb_src[c]   <= w_ch_src[c];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (FU_NUM=4, CDB_NUM=2, BUF_DEPTH=2).
// Expected broadcasts are queued in channel order as stimulus is issued; a
// negedge monitor pops and compares every valid channel.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned FU_NUM    = 4;
   localparam int unsigned CDB_NUM   = 2;
   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned SRC_W     = 2;

   typedef struct packed {
      logic [SRC_W-1:0]  src;
      logic [TAG_W-1:0]  tag;
      logic [XLEN_W-1:0] value;
   } exp_t;

   logic                           clock;
   logic                           reset_n;
   logic                           flush;
   logic [FU_NUM-1:0]              fu_valid;
   logic [FU_NUM-1:0][XLEN_W-1:0]  fu_value;
   logic [FU_NUM-1:0][TAG_W-1:0]   fu_tag;
   logic [FU_NUM-1:0]              fu_ready;
   logic [CDB_NUM-1:0]             cdb_valid;
   logic [CDB_NUM-1:0][TAG_W-1:0]  cdb_tag;
   logic [CDB_NUM-1:0][XLEN_W-1:0] cdb_value;
   logic [CDB_NUM-1:0][SRC_W-1:0]  cdb_src;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   cdb_arbiter #(
      .FU_NUM    (FU_NUM),
      .CDB_NUM   (CDB_NUM),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_value  (fu_value),
      .fu_tag    (fu_tag),
      .fu_ready  (fu_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [XLEN_W-1:0] val_of(input logic [TAG_W-1:0] t);
      return XLEN_W'(32'hB000_0000 + 32'(t));
   endfunction

   function automatic logic [TAG_W-1:0] bp_tag(input int f, input int k);
      case (f)
         0:       return TAG_W'(8'h10 + k);
         1:       return TAG_W'(8'h01 + k);
         default: return TAG_W'(8'h20 + k);
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      fu_valid = '0;
      flush    = 1'b0;
   endtask

   task automatic present(input int fu, input logic [TAG_W-1:0] t, input logic [XLEN_W-1:0] v);
      fu_valid[fu] = 1'b1;
      fu_tag[fu]   = t;
      fu_value[fu] = v;
   endtask

   task automatic expect_beat(input int src, input logic [TAG_W-1:0] t, input logic [XLEN_W-1:0] v);
      exp_q.push_back(exp_t'{src: SRC_W'(src), tag: t, value: v});
   endtask

   // Scoreboard monitor: every valid channel must match the next expected beat
   always @(negedge clock) begin
      if (reset_n && (cdb_valid != '0)) begin
         chk("channel_packing", 64'(cdb_valid[0]), 64'(1));
         for (int c = 0; c < CDB_NUM; c++) begin
            if (cdb_valid[1'(c)]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_beat ch%0d: got src=%0d tag=%0h value=%0h, nothing expected",
                           c, cdb_src[1'(c)], cdb_tag[1'(c)], cdb_value[1'(c)]);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk($sformatf("beat_ch%0d{src,tag,value}", c),
                      64'({cdb_src[1'(c)], cdb_tag[1'(c)], cdb_value[1'(c)]}), 64'(mon_e));
               end
            end else begin
               chk($sformatf("idle_ch%0d_zero", c),
                   64'({cdb_src[1'(c)], cdb_tag[1'(c)], cdb_value[1'(c)]}), 64'(0));
            end
         end
      end
   end

   initial begin
      logic [FU_NUM-1:0] hs;
      int acc [3];

      reset_n  = 1'b0;
      flush    = 1'b0;
      fu_valid = '1;
      fu_tag   = '0;
      fu_value = '0;

      // Reset held for three cycles with every FU valid
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("reset_fu_ready", 64'(fu_ready), 64'(0));
         chk("reset_cdb_valid", 64'(cdb_valid), 64'(0));
      end
      chk("reset_cdb_value", 64'(cdb_value), 64'(0));
      chk("reset_cdb_tag_src", 64'({cdb_src, cdb_tag}), 64'(0));
      step();
      fu_valid = '0;
      reset_n  = 1'b1;
      @(negedge clock);
      chk("post_reset_fu_ready", 64'(fu_ready), 64'hF);
      step();

      // Fairness: four results in one cycle with rr_ptr at 0
      for (int i = 0; i < 4; i++) begin
         present(i, TAG_W'(8 + i), val_of(TAG_W'(8 + i)));
         expect_beat(i, TAG_W'(8 + i), val_of(TAG_W'(8 + i)));
      end
      step();
      idle();
      @(negedge clock);
      chk("fair_no_bypass", 64'(cdb_valid), 64'(0));
      step();
      @(negedge clock);
      chk("fair_beat1_valid", 64'(cdb_valid), 64'(2'b11));
      chk("fair_beat1_src", 64'(cdb_src), 64'({2'd1, 2'd0}));
      step();
      @(negedge clock);
      chk("fair_beat2_valid", 64'(cdb_valid), 64'(2'b11));
      chk("fair_beat2_src", 64'(cdb_src), 64'({2'd3, 2'd2}));
      step();
      @(negedge clock);
      chk("fair_idle", 64'(cdb_valid), 64'(0));
      step();

      // Single result: FU2, tag 5, value 0xDEAD, two-cycle latency
      present(2, TAG_W'(5), XLEN_W'(32'hDEAD));
      expect_beat(2, TAG_W'(5), XLEN_W'(32'hDEAD));
      step();
      idle();
      @(negedge clock);
      chk("single_t1_idle", 64'(cdb_valid), 64'(0));
      step();
      @(negedge clock);
      chk("single_valid", 64'(cdb_valid), 64'(2'b01));
      chk("single_tag", 64'(cdb_tag[0]), 64'(5));
      chk("single_value", 64'(cdb_value[0]), 64'h0000_DEAD);
      chk("single_src", 64'(cdb_src[0]), 64'(2));
      step();
      @(negedge clock);
      chk("single_after_idle", 64'(cdb_valid), 64'(0));
      step();

      // Backpressure: FU0..FU2 each hand over three results under valid/ready
      expect_beat(0, 6'h10, val_of(6'h10));
      expect_beat(1, 6'h01, val_of(6'h01));
      expect_beat(2, 6'h20, val_of(6'h20));
      expect_beat(0, 6'h11, val_of(6'h11));
      expect_beat(1, 6'h02, val_of(6'h02));
      expect_beat(2, 6'h21, val_of(6'h21));
      expect_beat(0, 6'h12, val_of(6'h12));
      expect_beat(1, 6'h03, val_of(6'h03));
      expect_beat(2, 6'h22, val_of(6'h22));
      acc = '{0, 0, 0};
      for (int cyc = 0; cyc < 6; cyc++) begin
         fu_valid = '0;
         for (int f = 0; f < 3; f++) begin
            if (acc[f] < 3) present(f, bp_tag(f, acc[f]), val_of(bp_tag(f, acc[f])));
         end
         @(negedge clock);
         if (cyc == 2) chk("bp_ready_fu2_full", 64'(fu_ready), 64'(4'b1011));
         if (cyc == 3) chk("bp_ready_fu1_full", 64'(fu_ready), 64'(4'b1101));
         hs = fu_valid & fu_ready;
         step();
         for (int f = 0; f < 3; f++) begin
            if (hs[f]) acc[f]++;
         end
      end
      chk("bp_all_accepted", 64'({acc[2][3:0], acc[1][3:0], acc[0][3:0]}), 64'h333);
      idle();
      step();
      step();

      // Wrap: rr_ptr is 3, only FU3 and FU0 hold results
      present(3, 6'h33, val_of(6'h33));
      present(0, 6'h30, val_of(6'h30));
      expect_beat(3, 6'h33, val_of(6'h33));
      expect_beat(0, 6'h30, val_of(6'h30));
      step();
      idle();
      step();
      // Next scan must start at FU1
      present(0, 6'h00, val_of(6'h00));
      present(1, 6'h01, val_of(6'h01));
      present(2, 6'h02, val_of(6'h02));
      expect_beat(1, 6'h01, val_of(6'h01));
      expect_beat(2, 6'h02, val_of(6'h02));
      expect_beat(0, 6'h00, val_of(6'h00));
      @(negedge clock);
      chk("wrap_valid", 64'(cdb_valid), 64'(2'b11));
      chk("wrap_src", 64'(cdb_src), 64'({2'd0, 2'd3}));
      step();
      idle();
      step();
      @(negedge clock);
      chk("wrap_next_src", 64'(cdb_src), 64'({2'd2, 2'd1}));
      step();
      @(negedge clock);
      chk("wrap_tail_valid", 64'(cdb_valid), 64'(2'b01));
      step();
      step();

      // Flush: three buffered results plus a same-cycle FU0 push are dropped
      present(0, 6'h15, val_of(6'h15));
      present(1, 6'h16, val_of(6'h16));
      present(2, 6'h17, val_of(6'h17));
      step();
      fu_valid = '0;
      present(0, 6'h18, val_of(6'h18));
      flush = 1'b1;
      @(negedge clock);
      chk("flush_cycle_prior_outputs", 64'(cdb_valid), 64'(0));
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("post_flush_no_valid", 64'(cdb_valid), 64'(0));
         chk("post_flush_ready", 64'(fu_ready), 64'hF);
         step();
      end

      // rr_ptr must be back at 0 after the flush
      for (int i = 0; i < 4; i++) begin
         present(i, TAG_W'(8'h28 + i), val_of(TAG_W'(8'h28 + i)));
         expect_beat(i, TAG_W'(8'h28 + i), val_of(TAG_W'(8'h28 + i)));
      end
      step();
      idle();
      step();
      @(negedge clock);
      chk("post_flush_rr_beat1", 64'(cdb_src), 64'({2'd1, 2'd0}));
      step();
      @(negedge clock);
      chk("post_flush_rr_beat2", 64'(cdb_src), 64'({2'd3, 2'd2}));
      step();
      step();
      step();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Buffered, multi-channel successor to the combinational result bus: collects completed results from `FU_NUM` functional units through per-FU FIFOs and broadcasts up to `CDB_NUM` of them per cycle to the ROB and reservation stations. Selection is round-robin, so no functional unit starves. Outputs are registered, and a flush input squashes all in-flight results on branch mispredict. The block sits between the FU completion ports and the ROB/RS tag-match logic.

## Interface
- `FU_NUM`, 4: number of functional-unit result ports; must be ≥2.
- `CDB_NUM`, 2: number of broadcast channels per cycle; 1 ≤ `CDB_NUM` ≤ `FU_NUM`.
- `BUF_DEPTH`, 2: entries per FU result FIFO; must be ≥1.
- Data width is `` `XLEN ``; tag width is `` `ROB_TAG_LEN ``.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all buffered and registered results.
- `fu_valid` in `FU_NUM`: FU i presents a result.
- `fu_value` in `FU_NUM`×`XLEN`: result data per FU.
- `fu_tag` in `FU_NUM`×`ROB_TAG_LEN`: destination ROB tag per FU.
- `fu_ready` out `FU_NUM`: FU i may hand over a result this cycle.
- `cdb_valid` out `CDB_NUM`: channel c carries a result.
- `cdb_tag` out `CDB_NUM`×`ROB_TAG_LEN`: broadcast ROB tag.
- `cdb_value` out `CDB_NUM`×`XLEN`: broadcast value.
- `cdb_src` out `CDB_NUM`×`$clog2(FU_NUM)`: index of the source FU.

## Operation
- **FIFOs.** One FIFO per FU holds {tag, value}, with occupancy counter width `$clog2(BUF_DEPTH+1)`.
- **Push.** FIFO i pushes when `fu_valid[i] && fu_ready[i]` and `flush` is low.
- **Ready.** `fu_ready[i] = reset_n && (count[i] < BUF_DEPTH)`.
  - Ready is computed from the registered count only; there is no combinational path from arbitration to `fu_ready`.
  - A full FIFO deasserts ready even if it pops that cycle.
- **Arbitration.** Combinational, over the non-empty FIFO heads.
  - Scan FU indices `rr_ptr`, `rr_ptr+1`, … modulo `FU_NUM`.
  - The first non-empty FIFO goes to channel 0, the next to channel 1, and so on, up to `CDB_NUM` grants.
- **Pop.** Each granted FIFO pops exactly one entry; at most one grant per FU per cycle.
- **Output registers.** Each granted head is registered into its channel.
  - Channels without a grant register `cdb_valid=0` and `cdb_tag`, `cdb_value`, `cdb_src` = 0.
  - Granted channels are always packed from channel 0 upward with no holes.
- **Round-robin pointer.** `rr_ptr` advances to (last granted index + 1) mod `FU_NUM`; it is unchanged when nothing is granted.
- **Ordering.** Results from the same FU are broadcast in acceptance order; there is no ordering guarantee across FUs.
- **Flush.** At the flush edge:
  - all counts are cleared;
  - `rr_ptr` is set to 0 and all `cdb_valid` bits are cleared;
  - any push in the same cycle is discarded.
  - Outputs visible during the flush cycle itself are pre-flush values; consumers qualify them with their own flush.
- **Simultaneous push and pop** on the same FIFO when not full: the count is unchanged and both take effect.

## Timing
- **Reset (async assert, `reset_n`=0):**
  - all FIFOs empty, `rr_ptr`=0;
  - `cdb_valid`=0, `cdb_tag`=0, `cdb_value`=0, `cdb_src`=0;
  - `fu_ready`=0 while in reset, all ones in the first cycle after release.
- **Reset mid-operation:** all buffered results are lost immediately; there is no partial-drain behaviour.
- **Latency:** a handshake in cycle t puts the entry in the FIFO in t+1; the earliest broadcast is visible in cycle t+2. There is no FIFO bypass.
- **Throughput:** `CDB_NUM` results per cycle sustained; each FU sustains 1 result per cycle once `BUF_DEPTH` ≥ 2.
- **Full boundary:** with `BUF_DEPTH`=1, a continuously valid FU alternates accept and stall.
- **Wrap-around:** `rr_ptr` of `FU_NUM-1` followed by one grant at that index wraps `rr_ptr` to 0. Scanning also wraps past `FU_NUM-1`.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `fu_valid`=4'b1111 → `fu_ready`=0 and `cdb_valid`=0 throughout. After release, `fu_ready`=4'b1111.
- **Single result:** FU2 presents tag 5, value 0xDEAD in cycle 1 → cycle 3 shows `cdb_valid`=2'b01, `cdb_tag`=5, `cdb_value`=0xDEAD, `cdb_src`=2. Cycle 4 is idle.
- **Fairness:** all 4 FUs present one result in the same cycle (`CDB_NUM`=2, `rr_ptr`=0) → first broadcast has FU0 and FU1, the next has FU2 and FU3, then `rr_ptr`=0.
- **Backpressure:** FU1 is valid every cycle with tags 1,2,3,… while only FU1 and FU0 compete (`CDB_NUM`=1, FU0 also continuous) → FU1's `fu_ready` drops when 2 entries are held. Tags then emerge in order 1,2,3 with no loss or duplication.
- **Flush:** 3 results are buffered and `flush` is pulsed for one cycle while FU0 is valid → no `cdb_valid` in the following cycles, FU0's result is dropped, and all counts read 0.
- **Wrap:** `rr_ptr`=3 with only FU3 and FU0 non-empty (`CDB_NUM`=2) → channel 0 carries `cdb_src`=3, channel 1 carries `cdb_src`=0, and the next `rr_ptr`=1.
